// File: rtl/isqrt_iter.sv
// rtl/isqrt_iter.sv - iterative 32-bit integer square root, one result bit per cycle
// Restoring digit-by-digit root: 16 iterations, first one on the accepting edge.
module isqrt_iter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        x_vld,
   input  logic [31:0] x,
   output logic        y_vld,
   output logic [15:0] y,
   output logic        busy
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_CALC = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] op_q, op_d;
   logic [17:0] rem_q, rem_d;
   logic [15:0] root_q, root_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] y_q, y_d;
   logic        y_vld_q, y_vld_d;

   logic [31:0] op_src;
   logic [17:0] rem_src;
   logic [15:0] root_src;
   logic [19:0] trial;
   logic [19:0] test;
   logic        ge;
   logic [17:0] rem_it;
   logic [15:0] root_it;

   // In IDLE the iteration runs on the fresh operand with a cleared remainder/root.
   always_comb begin
      op_src   = (state_q == S_IDLE) ? x : op_q;
      rem_src  = (state_q == S_IDLE) ? 18'd0 : rem_q;
      root_src = (state_q == S_IDLE) ? 16'd0 : root_q;
      trial    = {rem_src, op_src[31:30]};
      test     = {2'b00, root_src, 2'b01};
      ge       = (trial >= test);
      rem_it   = ge ? 18'(trial - test) : trial[17:0];
      root_it  = {root_src[14:0], ge};
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rem_d   = rem_q;
      root_d  = root_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      y_vld_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (x_vld) begin
               op_d    = {op_src[29:0], 2'b00};
               rem_d   = rem_it;
               root_d  = root_it;
               cnt_d   = 4'd1;
               state_d = S_CALC;
            end
         end
         default: begin
            op_d   = {op_src[29:0], 2'b00};
            rem_d  = rem_it;
            root_d = root_it;
            if (cnt_q == 4'd15) begin
               cnt_d   = 4'd0;
               state_d = S_IDLE;
               y_d     = root_it;
               y_vld_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= 32'd0;
         rem_q   <= 18'd0;
         root_q  <= 16'd0;
         cnt_q   <= 4'd0;
         y_q     <= 16'd0;
         y_vld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         root_q  <= root_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         y_vld_q <= y_vld_d;
      end
   end

   assign y_vld = y_vld_q;
   assign y     = y_q;
   assign busy  = (state_q == S_CALC);

endmodule

// File: doc/isqrt_iter.md
ISQRT_ITER -- requirements
Module: isqrt_iter

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits and the result width at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 x_vld  input  1  request strobe; x is valid in the same cycle.
REQ-005 x  input  32  unsigned operand.
REQ-006 y_vld  output  1  one-cycle result strobe.
REQ-007 y  output  16  unsigned result, floor(sqrt(x)).
REQ-008 busy  output  1  high while an accepted request is still iterating.

Function
REQ-009 The block SHALL compute y = floor(sqrt(x)) exactly, for every 32-bit unsigned x.
REQ-010 The block SHALL use a non-pipelined, iterative digit-by-digit restoring algorithm that resolves one result bit (two operand bits) per iteration, for 16 iterations in total.
REQ-011 The datapath SHALL consist of a 32-bit operand shift register, a remainder of at least 18 bits, a 16-bit partial root, and a 4-bit iteration counter; no multiplier is permitted.
REQ-012 The FSM SHALL have exactly two states: IDLE and CALC.
REQ-013 The block SHALL accept a request when x_vld=1 on a rising edge and the state is IDLE.
REQ-014 On the accepting edge, the block SHALL load the operand, perform iteration 1, and move to CALC.
REQ-015 In CALC, the block SHALL perform one iteration per edge.
REQ-016 On the edge that completes iteration 16, the block SHALL return to IDLE.
REQ-017 Latency SHALL be fixed: for x_vld accepted in cycle t, y_vld=1 in cycle t+16 only, and y holds the result in that cycle.
REQ-018 busy SHALL be 1 exactly in cycles t+1..t+15 (state CALC) and 0 otherwise.
REQ-019 y_vld SHALL be a registered pulse, exactly one cycle wide per accepted request.
REQ-020 y SHALL hold the last result after the strobe, unchanged until the next result is produced.
REQ-021 Back-to-back operation: the block SHALL accept x_vld in the same cycle y_vld=1 (the state is IDLE then). The new result SHALL appear 16 cycles later, and the old y SHALL be unaffected in the strobe cycle.
REQ-022 x_vld=1 while busy=1 SHALL be ignored entirely: no state change, no extra y_vld, and the current computation is not disturbed.
REQ-023 x SHALL be sampled only on the accepting edge; changes to x during CALC SHALL have no effect.
REQ-024 The throughput SHALL be at most one result per 16 cycles.
REQ-025 Boundary values SHALL give: x=0 -> 0, x=1 -> 1, x=3 -> 1, x=4 -> 2, x=0xFFFFFFFF -> 0xFFFF. The remainder SHALL not overflow for any x.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force state=IDLE, y_vld=0, y=0, busy=0, and clear the counter, remainder and root.
REQ-027 The block SHALL release reset synchronously with respect to internal use, and the first request SHALL be accepted on the first rising edge after rst_n rises.
REQ-028 Reset asserted mid-computation SHALL abort it, with no y_vld ever issued for the aborted request; y reads 0 after reset.
REQ-029 No output SHALL depend combinationally on x_vld or x.

Verification
REQ-030 Single request: x=1000000 in cycle t -> y_vld=1 only in cycle t+16 with y=1000; busy=1 in t+1..t+15.
REQ-031 Boundaries: x=0, 1, 3, 4, 15, 16, 0xFFFFFFFF issued sequentially -> y=0, 1, 1, 2, 3, 4, 65535.
REQ-032 Back-to-back: x=144 in cycle t, then x=4000000 in cycle t+16 -> y=12 at t+16, y=2000 at t+32, and exactly two y_vld pulses.
REQ-033 Busy ignore: x=81 in cycle t, x=9 pulsed in cycle t+5, x changed every cycle during CALC -> a single y_vld at t+16 with y=9 (sqrt of 81), and no second pulse.
REQ-034 Reset mid-operation: x=625 in cycle t, rst_n=0 in cycle t+8 (asynchronous, mid-cycle) -> y_vld, busy and y go to 0 immediately, and no pulse occurs within 40 cycles. After release, x=625 -> y=25 16 cycles later.
REQ-035 Random: 10^5 random x, including back-to-back and idle gaps, checked against a floor(sqrt) reference model -> zero mismatches, and the pulse count equals the accepted request count.
